uart_cmd_assembler: RTL and testbench
=====================================

// Module: uart_cmd_assembler
// PURPOSE
//  Robot-side command/response framer behind the UART receiver/transmitter pair.
//  - Command path: assembles two received bytes (high byte first) into a 16-bit command.
//  - Response path: frames the single-byte response (0xA5 positive ack) back out.
//  - Feeds cmd/cmd_rdy to the command processor and consumes its resp/send_resp.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  inter-byte timeout in clk cycles (used only with CMD_TIMEOUT_EN)
// PORTS
//  clk          in   1   system clock; all logic on posedge
//  rst          in   1   synchronous, active-high reset
//  rx_rdy       in   1   UART receiver holds a byte; stays high until clr_rx_rdy
//  rx_data      in   8   received byte
//  clr_rx_rdy   out  1   one-cycle pulse acknowledging rx byte
//  cmd          out  16  last complete command {hi,lo}
//  cmd_rdy      out  1   command valid; held until cleared
//  clr_cmd_rdy  in   1   consumer acknowledge of cmd
//  overrun      out  1   one-cycle pulse: new frame started while cmd_rdy still set
//  frame_err    out  1   one-cycle pulse: inter-byte timeout (0 without CMD_TIMEOUT_EN)
//  resp         in   8   response byte
//  send_resp    in   1   one-cycle request to transmit resp
//  trmt         out  1   one-cycle start pulse to UART transmitter
//  tx_data      out  8   byte to transmit; stable from trmt until tx_done
//  tx_done      in   1   transmitter finished byte
//  resp_sent    out  1   one-cycle pulse on completion of response
// BEHAVIOUR
//  - Reset: all outputs 0. rx FSM is IDLE. tx FSM is TX_IDLE. hi-byte shadow and counter are 0.
//  - rx_rdy is sampled only in cycles where clr_rx_rdy is 0.
//    This prevents double-accepting one byte during the receiver's 1-cycle clear latency.
//  - rx FSM states: IDLE, WAIT_LO.
//  - IDLE + rx_rdy:
//    - latch rx_data into the hi shadow;
//    - clr_rx_rdy=1 next cycle;
//    - cmd_rdy cleared; overrun pulses if cmd_rdy was 1;
//    - go to WAIT_LO.
//  - WAIT_LO + rx_rdy:
//    - cmd <= {hi,rx_data} atomically; cmd_rdy=1 and clr_rx_rdy=1 next cycle;
//    - go to IDLE.
//    - cmd never shows a half-updated value.
//  - cmd_rdy priority: set (frame completion) > clear (clr_cmd_rdy or new hi byte) > hold.
//    clr_cmd_rdy has no effect on cmd.
//  - tx FSM states: TX_IDLE, TX_BUSY.
//  - TX_IDLE + send_resp:
//    - tx_data <= resp; trmt=1 for the next cycle only;
//    - go to TX_BUSY.
//  - TX_BUSY + tx_done: resp_sent=1 next cycle; go to TX_IDLE.
//    send_resp while TX_BUSY is ignored; it is not queued.
//  - The rx and tx FSMs are fully independent. Simultaneous rx and tx activity is legal.
//  - Reset mid-frame: the partial hi byte is discarded. The next received byte is a high byte.
// CONFIGURATION
//  CMD_TIMEOUT_EN defined:
//   - A counter runs in WAIT_LO and is cleared on entry.
//   - If it reaches TIMEOUT_CYCLES-1 with no rx_rdy: discard hi, pulse frame_err, go to IDLE.
//   - rx_rdy on the terminal cycle wins: the byte is taken as the low byte and no frame_err fires.
//  CMD_TIMEOUT_EN undefined:
//   - No counter; WAIT_LO waits indefinitely.
//   - frame_err is tied 0. The port list is unchanged.
// STRUCTURE
//  - Package knight_uart_pkg:
//    - rx_state_t {IDLE,WAIT_LO} and tx_state_t {TX_IDLE,TX_BUSY};
//    - UART_POS_ACK=8'hA5, MOVE_POS_ACK=8'h5A, CMD_W=16.
//  - Sub-module resp_tx_ctrl holds the tx FSM (send_resp/resp/tx_done -> trmt/tx_data/resp_sent).
//  - The rx FSM, shadow and timeout counter stay in the top.
// TESTING
//  1. Bytes 0x29 then 0x33 via rx_rdy (held until clr_rx_rdy)
//     -> one clr_rx_rdy pulse per byte; cmd=16'h2933 and cmd_rdy=1 on the cycle after the lo byte is sampled.
//  2. Pulse clr_cmd_rdy after test 1 -> cmd_rdy=0 next cycle; cmd stays 16'h2933.
//  3. Frame 0x40,0x00 left uncleared, then byte 0x51 -> overrun pulse and cmd_rdy=0;
//     cmd holds 16'h4000 until byte 0x0F arrives -> cmd=16'h510F.
//  4. send_resp with resp=0xA5 -> trmt 1-cycle pulse, tx_data=0xA5;
//     a second send_resp before tx_done is ignored; tx_done -> single resp_sent pulse.
//  5. CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100: byte 0x12, idle 100 cycles -> frame_err pulse, no cmd_rdy;
//     then bytes 0x12,0x34 -> cmd=16'h1234.
//  6. rst asserted 1 cycle after hi byte 0x77 -> all outputs 0; bytes 0xAB,0xCD -> cmd=16'hABCD.

Source files
------------

// File: rtl/knight_uart_pkg.sv
// Shared types and constants for the UART command/response framer.
package knight_uart_pkg;

  localparam int         CMD_W        = 16;
  localparam logic [7:0] UART_POS_ACK = 8'hA5;
  localparam logic [7:0] MOVE_POS_ACK = 8'h5A;

  typedef enum logic {IDLE, WAIT_LO} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

endpackage

// File: rtl/resp_tx_ctrl.sv
// Response transmit controller: launches one byte into the UART transmitter and
// reports completion. Requests arriving while a byte is in flight are dropped.
module resp_tx_ctrl
  import knight_uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] resp,
  input  logic       send_resp,
  input  logic       tx_done,
  output logic       trmt,
  output logic [7:0] tx_data,
  output logic       resp_sent
);

  tx_state_t  state, state_nxt;
  logic [7:0] tx_data_nxt;
  logic       trmt_nxt, resp_sent_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TX_IDLE;
      trmt      <= 1'b0;
      tx_data   <= 8'h00;
      resp_sent <= 1'b0;
    end else begin
      state     <= state_nxt;
      trmt      <= trmt_nxt;
      tx_data   <= tx_data_nxt;
      resp_sent <= resp_sent_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    tx_data_nxt   = tx_data;
    trmt_nxt      = 1'b0;
    resp_sent_nxt = 1'b0;
    case (state)
      TX_IDLE: if (send_resp) begin
        tx_data_nxt = resp;
        trmt_nxt    = 1'b1;
        state_nxt   = TX_BUSY;
      end
      TX_BUSY: if (tx_done) begin
        resp_sent_nxt = 1'b1;
        state_nxt     = TX_IDLE;
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cmd_assembler.sv
// Assembles two UART bytes (high first) into a 16-bit command and frames the response byte.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_assembler
  import knight_uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_rdy,
  input  logic [7:0]       rx_data,
  output logic             clr_rx_rdy,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  output logic             overrun,
  output logic             frame_err,
  input  logic [7:0]       resp,
  input  logic             send_resp,
  output logic             trmt,
  output logic [7:0]       tx_data,
  input  logic             tx_done,
  output logic             resp_sent
);

  rx_state_t        state, state_nxt;
  logic [7:0]       hi, hi_nxt;
  logic [CMD_W-1:0] cmd_nxt;
  logic             cmd_rdy_nxt, clr_nxt, overrun_nxt;
  logic             accept;

  // A byte still flagged during the receiver's clear latency must not be taken twice.
  assign accept = rx_rdy & ~clr_rx_rdy;

`ifdef CMD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             frame_err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      frame_err <= frame_err_nxt;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hi         <= 8'h00;
      cmd        <= '0;
      cmd_rdy    <= 1'b0;
      clr_rx_rdy <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      hi         <= hi_nxt;
      cmd        <= cmd_nxt;
      cmd_rdy    <= cmd_rdy_nxt;
      clr_rx_rdy <= clr_nxt;
      overrun    <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hi_nxt      = hi;
    cmd_nxt     = cmd;
    cmd_rdy_nxt = clr_cmd_rdy ? 1'b0 : cmd_rdy;
    clr_nxt     = 1'b0;
    overrun_nxt = 1'b0;
`ifdef CMD_TIMEOUT_EN
    cnt_nxt       = '0;
    frame_err_nxt = 1'b0;
`endif
    case (state)
      IDLE: if (accept) begin
        hi_nxt      = rx_data;
        clr_nxt     = 1'b1;
        overrun_nxt = cmd_rdy;
        cmd_rdy_nxt = 1'b0;
        state_nxt   = WAIT_LO;
      end
      WAIT_LO: begin
        if (accept) begin
          // Whole command updates in one edge, together with the valid flag.
          cmd_nxt     = {hi, rx_data};
          cmd_rdy_nxt = 1'b1;
          clr_nxt     = 1'b1;
          state_nxt   = IDLE;
        end
`ifdef CMD_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          hi_nxt        = 8'h00;
          frame_err_nxt = 1'b1;
          state_nxt     = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  resp_tx_ctrl u_resp_tx_ctrl (
    .clk       (clk),
    .rst       (rst),
    .resp      (resp),
    .send_resp (send_resp),
    .tx_done   (tx_done),
    .trmt      (trmt),
    .tx_data   (tx_data),
    .resp_sent (resp_sent)
  );

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler: frame table, overrun, response path,
// inter-byte timeout (CMD_TIMEOUT_EN) and mid-frame reset.
module tb_uart_cmd_assembler;
  import knight_uart_pkg::*;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        overrun;
  logic        frame_err;
  logic [7:0]  resp;
  logic        send_resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        resp_sent;

  always #5 clk = ~clk;

  uart_cmd_assembler #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .resp        (resp),
    .send_resp   (send_resp),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .resp_sent   (resp_sent)
  );

  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] exp_cmd;
  } frame_vec_t;

  logic [15:0] exp_q[$];
  logic [7:0]  tx_q[$];
  int clr_cnt = 0, trmt_cnt = 0, sent_cnt = 0, bytes_sent = 0;
  logic rdy_q = 1'b0;

  always @(posedge clk) begin
    if (clr_rx_rdy) clr_cnt++;
    if (trmt)       trmt_cnt++;
    if (resp_sent)  sent_cnt++;
  end

  // Scoreboard: each new command and each transmit start is matched against a queued expectation.
  always @(negedge clk) begin
    if (cmd_rdy && !rdy_q) begin
      if (exp_q.size() == 0) begin
        ntests++; nfail++;
        $display("FAIL sb_cmd: unexpected command %h, none expected", cmd);
      end else check("sb_cmd", 32'(cmd), 32'(exp_q.pop_front()));
    end
    rdy_q = cmd_rdy;
    if (trmt) begin
      if (tx_q.size() == 0) begin
        ntests++; nfail++;
        $display("FAIL sb_tx: unexpected trmt with tx_data %h, none expected", tx_data);
      end else check("sb_tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
    end
  end

  // Receiver model: holds rx_rdy through the acknowledge cycle plus one more (clear latency).
  task automatic send_byte(input logic [7:0] b, output logic rdy_ack, output logic ovr_ack);
    int k;
    rx_data = b;
    rx_rdy  = 1'b1;
    bytes_sent++;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (clr_rx_rdy) break;
    end
    check("clr_rx_rdy_latency", 32'(k), 32'd0);
    rdy_ack = cmd_rdy;
    ovr_ack = overrun;
    @(negedge clk);
    check("clr_rx_rdy_single_pulse", 32'(clr_rx_rdy), 32'd0);
    rx_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input logic [15:0] exp);
    logic r, o;
    send_byte(hi, r, o);
    exp_q.push_back(exp);
    send_byte(lo, r, o);
    check("frame_cmd_rdy", 32'(r), 32'd1);
  endtask

  task automatic clear_cmd();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  function automatic logic [31:0] all_outputs();
    return {clr_rx_rdy, cmd_rdy, overrun, frame_err, trmt, resp_sent, tx_data, cmd};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_vec_t vecs[5];
    logic r, o;
    int k;
    vecs[0] = '{8'h29, 8'h33, 16'h2933};
    vecs[1] = '{8'h00, 8'h00, 16'h0000};
    vecs[2] = '{8'hFF, 8'hFF, 16'hFFFF};
    vecs[3] = '{8'h80, 8'h01, 16'h8001};
    vecs[4] = '{8'hA5, 8'h5A, 16'hA55A};

    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    resp = 8'h00; send_resp = 1'b0; tx_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Frame table, each followed by a consumer acknowledge.
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].hi, vecs[i].lo, vecs[i].exp_cmd);
      check("table_cmd", 32'(cmd), 32'(vecs[i].exp_cmd));
      clear_cmd();
      check("clr_cmd_rdy_clears", 32'(cmd_rdy), 32'd0);
      check("clr_cmd_rdy_keeps_cmd", 32'(cmd), 32'(vecs[i].exp_cmd));
    end

    // Overrun: new high byte while the previous command is still pending.
    send_frame(8'h40, 8'h00, 16'h4000);
    send_byte(8'h51, r, o);
    check("overrun_pulse", 32'(o), 32'd1);
    check("overrun_clears_rdy", 32'(r), 32'd0);
    check("overrun_single", 32'(overrun), 32'd0);
    check("cmd_held_mid_frame", 32'(cmd), 32'h4000);
    exp_q.push_back(16'h510F);
    send_byte(8'h0F, r, o);
    check("overrun_next_cmd", 32'(cmd), 32'h510F);
    check("no_overrun_on_lo", 32'(o), 32'd0);
    clear_cmd();

    // Response path with an ignored request while busy.
    resp = UART_POS_ACK; send_resp = 1'b1; tx_q.push_back(8'hA5);
    @(negedge clk);
    send_resp = 1'b0;
    check("trmt_pulse", 32'(trmt), 32'd1);
    check("tx_data_launch", 32'(tx_data), 32'hA5);
    @(negedge clk);
    check("trmt_one_cycle", 32'(trmt), 32'd0);
    resp = 8'h5A; send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    check("busy_send_ignored", 32'(trmt), 32'd0);
    repeat (3) @(negedge clk);
    check("tx_data_stable", 32'(tx_data), 32'hA5);
    check("no_early_resp_sent", 32'(resp_sent), 32'd0);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("resp_sent_pulse", 32'(resp_sent), 32'd1);
    @(negedge clk);
    check("resp_sent_one_cycle", 32'(resp_sent), 32'd0);

`ifdef CMD_TIMEOUT_EN
    // Abandoned frame: high byte then silence until the timeout fires.
    send_byte(8'h12, r, o);
    for (k = 0; k < 3 * TMO; k++) begin
      if (frame_err) break;
      @(negedge clk);
    end
    check("frame_err_latency", 32'(k), 32'(TMO - 1));
    check("frame_err_no_cmd", 32'(cmd_rdy), 32'd0);
    @(negedge clk);
    check("frame_err_single", 32'(frame_err), 32'd0);
    send_frame(8'h12, 8'h34, 16'h1234);
    check("after_timeout_cmd", 32'(cmd), 32'h1234);
`else
    // Without the timeout the low byte may arrive arbitrarily late.
    send_byte(8'h12, r, o);
    k = 0;
    repeat (3 * TMO) begin
      @(negedge clk);
      if (frame_err || cmd_rdy) k++;
    end
    check("no_timeout_activity", 32'(k), 32'd0);
    exp_q.push_back(16'h1234);
    send_byte(8'h34, r, o);
    check("late_lo_cmd_rdy", 32'(r), 32'd1);
    check("late_lo_cmd", 32'(cmd), 32'h1234);
`endif
    clear_cmd();

    // Reset one cycle after a high byte: partial frame discarded.
    send_byte(8'h77, r, o);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_reset_outputs", all_outputs(), 32'd0);
    rst = 1'b0;
    send_frame(8'hAB, 8'hCD, 16'hABCD);
    check("post_reset_cmd", 32'(cmd), 32'hABCD);
    clear_cmd();
    repeat (2) @(negedge clk);

    check("sb_cmd_drained", 32'(exp_q.size()), 32'd0);
    check("sb_tx_drained", 32'(tx_q.size()), 32'd0);
    check("clr_rx_rdy_count", 32'(clr_cnt), 32'(bytes_sent));
    check("trmt_count", 32'(trmt_cnt), 32'd1);
    check("resp_sent_count", 32'(sent_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
